// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states,
// the latched request bundle and the request legality check.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // Illegal size, misaligned access or word index past the memory.
   function automatic logic req_bad(
      input logic [1:0]  size,
      input logic [31:0] addr,
      input int unsigned depth
   );
      logic w_bad;
      w_bad = 1'b0;
      if (size == 2'd3)
         w_bad = 1'b1;
      if (size == SZ_H && addr[0])
         w_bad = 1'b1;
      if (size == SZ_W && addr[1:0] != 2'b00)
         w_bad = 1'b1;
      if ({2'b00, addr[31:2]} >= 32'(depth))
         w_bad = 1'b1;
      return w_bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane logic: load extraction with sign/zero extension
// and sub-word merge of store data into a previously read word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_uns,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_ldata,
   output logic [31:0] o_merged
);

   logic [4:0]  w_sh;
   logic [31:0] w_shifted;
   logic [31:0] w_mask;
   logic [31:0] w_lane_mask;

   assign w_sh      = {i_lane, 3'b000};
   assign w_shifted = i_word >> w_sh;

   always_comb begin
      o_ldata = w_shifted;
      w_mask  = 32'hFFFF_FFFF;
      case (i_size)
         SZ_B: begin
            w_mask  = 32'h0000_00FF;
            o_ldata = {{24{~i_uns & w_shifted[7]}}, w_shifted[7:0]};
         end
         SZ_H: begin
            w_mask  = 32'h0000_FFFF;
            o_ldata = {{16{~i_uns & w_shifted[15]}}, w_shifted[15:0]};
         end
         default: ;
      endcase
   end

   assign w_lane_mask = w_mask << w_sh;
   assign o_merged    = (i_word & ~w_lane_mask)
                      | ((i_wdata << w_sh) & w_lane_mask);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one request at a time, read-modify-write for
// sub-word stores, response held until the consumer takes it.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wen,
   input  logic [31:0] mem_rdata
);

   state_e      r_state;
   state_e      w_next;
   req_t        r_req;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_rdata;
   logic        r_err;

   logic        w_accept;
   logic        w_bad;
   logic        w_word_st;
   logic [31:0] w_ldata;
   logic [31:0] w_merged;

   assign w_accept  = req_valid & req_ready;
   assign w_bad     = req_bad(req_size, req_addr, DEPTH_WORDS);
   assign w_word_st = req_we & (req_size == SZ_W);

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_bad)
                  w_next = ST_RESP;
               else if (w_word_st)
                  w_next = ST_WR;
               else
                  w_next = ST_RD;
            end
         end
         ST_RD:   w_next = r_req.we ? ST_WR : ST_RESP;
         ST_WR:   w_next = ST_RESP;
         ST_RESP: if (resp_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // The write strobe is gated by rst so a reset in WR never commits.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_wen    = 1'b0;
      unique case (r_state)
         ST_IDLE: req_ready  = 1'b1;
         ST_WR:   mem_wen    = ~rst;
         ST_RESP: resp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_req       <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_rdata <= '0;
                  r_err   <= w_bad;
                  if (!w_bad) begin
                     r_req <= '{
                        we:    req_we,
                        size:  req_size,
                        uns:   req_unsigned,
                        addr:  req_addr,
                        wdata: req_wdata
                     };
                  end
                  if (!w_bad && w_word_st)
                     r_mem_wdata <= req_wdata;
               end
            end
            ST_RD: begin
               if (r_req.we)
                  r_mem_wdata <= w_merged;
               else
                  r_rdata <= w_ldata;
            end
            default: ;
         endcase
      end
   end

   lsu_align u_align (
      .i_word   (mem_rdata),
      .i_lane   (r_req.addr[1:0]),
      .i_size   (r_req.size),
      .i_uns    (r_req.uns),
      .i_wdata  (r_req.wdata),
      .o_ldata  (w_ldata),
      .o_merged (w_merged)
   );

   assign mem_addr   = {2'b00, r_req.addr[31:2]};
   assign mem_wdata  = r_mem_wdata;
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule
